// File: rtl/mem_burst_master.sv
// Burst initiator for the 256x28 board memory: request handshake in, write/read
// beat streams to the client, single-port addr/in/we drive to the memory.
//
// state   | meaning
// S_IDLE  | waiting for a request, req_ready high
// S_WRITE | forwarding accepted write beats straight to memory
// S_READ  | filling the registered read beat, holding under backpressure
// S_DONE  | one-cycle completion pulse before returning to idle
module mem_burst_master #(
  parameter int DATA_W = 28,
  parameter int ADDR_W = 28,
  parameter int DEPTH  = 256,
  parameter int LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_cur;
  logic [IDX_W-1:0]  w_cur_inc;
  logic [LEN_W-1:0]  r_rem;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              w_req_acc;
  logic              w_wr_beat;
  logic              w_rd_load;
  logic              w_rd_take;

  assign w_cur_inc   = (r_cur == IDX_W'(DEPTH - 1)) ? '0 : r_cur + IDX_W'(1);
  assign o_mem_addr  = {{(ADDR_W - IDX_W){1'b0}}, r_cur};
  assign o_mem_wdata = i_wr_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_rd_last   = r_rd_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_mem_we    = 1'b0;
    o_done      = 1'b0;
    w_req_acc   = 1'b0;
    w_wr_beat   = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_take   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        w_req_acc   = i_req_valid;
        if (i_req_valid) w_next = i_req_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        o_wr_ready = 1'b1;
        o_mem_we   = i_wr_valid;
        w_wr_beat  = i_wr_valid;
        if (i_wr_valid && r_rem == '0) w_next = S_DONE;
      end
      S_READ: begin
        w_rd_take = r_rd_valid & i_rd_ready;
        w_rd_load = r_rd_pend & (~r_rd_valid | i_rd_ready);
        if (w_rd_take && r_rd_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_rd_pend means read beats are still to be fetched; r_rem alone cannot tell
  // "one beat left" from "last beat already loaded".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur      <= '0;
      r_rem      <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      if (w_req_acc) begin
        r_cur     <= IDX_W'(i_req_addr % DEPTH);
        r_rem     <= i_req_len;
        r_rd_pend <= ~i_req_write;
      end
      if (w_wr_beat || w_rd_load) begin
        r_cur <= w_cur_inc;
        if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
      end
      if (w_rd_load) begin
        r_rd_data  <= i_mem_rdata;
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_rem == '0);
        r_rd_pend  <= (r_rem != '0);
      end else if (w_rd_take) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 256x28 memory that
// reads combinationally and writes on the rising edge.
module tb_mem_burst_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [27:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [27:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [27:0] rd_data;
  logic        rd_last;
  logic        done;
  logic [27:0] mem_addr;
  logic [27:0] mem_wdata;
  logic        mem_we;
  logic [27:0] mem_rdata;

  logic [27:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  mem_burst_master dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_len   (req_len),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_data   (wr_data),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_rd_data   (rd_data),
    .o_rd_last   (rd_last),
    .o_done      (done),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with the master idle; returns at posedge+1 after acceptance.
  task automatic issue(input logic w, input logic [27:0] a, input logic [3:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr_stream(input int a, input int l, input logic [27:0] d0, input int stall_at);
    for (int k = 0; k <= l; k++) begin
      if (k == stall_at) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_stall_we", mem_we, 0);
        @(posedge clk); #1;
      end
      wr_valid = 1'b1;
      wr_data  = d0 + 28'(k);
      @(negedge clk);
      chk("wr_we", mem_we, 1);
      chk("wr_ready", wr_ready, 1);
      chk("wr_addr", mem_addr, (a + k) % 256);
      chk("wr_busy", req_ready, 0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", done, 1);
    chk("wr_done_we", mem_we, 0);
    chk("wr_done_busy", req_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic rd_collect(input int l, input logic [27:0] d0, input logic tog);
    int idx = 0;
    logic held_v = 1'b0;
    logic [27:0] held = '0;
    logic held_last = 1'b0;
    logic seen_done = 1'b0;
    for (int c = 1; c <= 60 && !seen_done; c++) begin
      rd_ready = tog ? c[0] : 1'b1;
      @(negedge clk);
      if (held_v) begin
        chk("rd_hold_data", rd_data, held);
        chk("rd_hold_last", rd_last, held_last);
      end
      held_v = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          chk("rd_data", rd_data, d0 + 28'(idx));
          chk("rd_last", rd_last, (idx == l) ? 1 : 0);
          if (!tog) chk("rd_cycle", c, 2 + idx);
          idx++;
        end else begin
          held_v    = 1'b1;
          held      = rd_data;
          held_last = rd_last;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk("rd_done_valid", rd_valid, 0);
        chk("rd_done_busy", req_ready, 0);
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    chk("rd_beats", idx, l + 1);
    chk("rd_done_seen", seen_done, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_req_ready", req_ready, 1);
    chk("init_rd_valid", rd_valid, 0);
    chk("init_done", done, 0);
    chk("init_wr_ready", wr_ready, 0);
    @(posedge clk); #1;

    // reset in the middle of a write burst
    issue(1'b1, 28'h40, 4'd7);
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      wr_data  = 28'h77 + 28'(k);
      @(posedge clk); #1;
    end
    wr_data = 28'h79;
    @(negedge clk);
    chk("pre_rst_we", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rd_valid", rd_valid, 0);
    chk("post_rst_done", done, 0);
    chk("kept_mem40", mem[8'h40], 28'h77);
    chk("kept_mem41", mem[8'h41], 28'h78);
    @(posedge clk); #1;

    // board write and read back
    issue(1'b1, 28'h10, 4'd7);
    wr_stream(16, 7, 28'd1, -1);
    chk("idle_after_wr", req_ready, 1);
    for (int k = 0; k < 8; k++) chk("board_mem", mem[8'h10 + 8'(k)], 28'(k + 1));
    issue(1'b0, 28'h10, 4'd7);
    rd_collect(7, 28'd1, 1'b0);
    issue(1'b0, 28'h10, 4'd7);
    rd_collect(7, 28'd1, 1'b1);

    // address wrap, with a stall beat, then the same start given as 0x1FE
    issue(1'b1, 28'hFE, 4'd3);
    wr_stream(254, 3, 28'hA, 1);
    chk("wrap_fe", mem[8'hFE], 28'hA);
    chk("wrap_ff", mem[8'hFF], 28'hB);
    chk("wrap_00", mem[8'h00], 28'hC);
    chk("wrap_01", mem[8'h01], 28'hD);
    issue(1'b1, 28'h1FE, 4'd3);
    wr_stream(254, 3, 28'h100, -1);
    chk("wrap2_fe", mem[8'hFE], 28'h100);
    chk("wrap2_01", mem[8'h01], 28'h103);
    issue(1'b0, 28'h1FE, 4'd3);
    rd_collect(3, 28'h100, 1'b0);

    // second request held off during a write burst, accepted after done
    issue(1'b1, 28'h20, 4'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 28'h20; req_len = 4'd1;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1;
      wr_data  = 28'h55 + 28'(k);
      @(negedge clk);
      chk("busy_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("busy_done", done, 1);
    chk("busy_done_ready", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd_collect(1, 28'h55, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
